// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Definitions shared by the serial scan controller and its pattern matcher:
//   - scan_state_t  : controller state encoding (IDLE / SHIFT / DONE)
//   - cnt_width()   : width of a counter that must hold 0..word_w
//   - idx_width()   : width of a bit index that must hold 0..word_w-1
//   - DEF_*         : widths for the default 20-bit job word
// ---------------------------------------------------------------------------
package scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } scan_state_t;

   localparam int DEF_WORD_W = 20;

   function automatic int cnt_width(input int word_w);
      return $clog2(word_w + 1);
   endfunction

   function automatic int idx_width(input int word_w);
      return $clog2(word_w);
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WORD_W);
   localparam int DEF_IDX_W = idx_width(DEF_WORD_W);

endpackage

// File: rtl/pattern_matcher.sv
// ---------------------------------------------------------------------------
// pattern_matcher
// Bit-serial pattern detector. Keeps the recent serial history and a fill
// counter, and flags a hit in the same cycle as the bit that completes a
// PAT_W-bit window (oldest bit first) equal to pattern.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear of history and fill count (new job / abort)
//   bit_in    : live serial bit
//   bit_en    : bit_in is valid this cycle and is consumed at the next edge
//   pattern   : pattern to detect, MSB = oldest bit
//   hit       : combinational match flag for the live bit
// ---------------------------------------------------------------------------
module pattern_matcher #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit
);

   localparam int                FILL_W    = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

   // The PAT_W-bit comparison window is the PAT_W-1 stored bits plus the live
   // bit, so a hit is known in the cycle the completing bit is presented.
   logic [PAT_W-2:0]  hist_reg;
   logic [FILL_W-1:0] fill_reg;
   logic [PAT_W-1:0]  window;

   assign window = {hist_reg, bit_in};

   // Windows ending before PAT_W real bits have been seen never count.
   assign hit = bit_en && (fill_reg == FILL_FULL) && (window == pattern);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist_reg <= '0;
         fill_reg <= '0;
      end else if (bit_en) begin
         hist_reg <= window[PAT_W-2:0];
         if (fill_reg != FILL_FULL) begin
            fill_reg <= fill_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_scan_ctrl.sv
// ---------------------------------------------------------------------------
// serial_scan_ctrl
// Accepts a job word and pattern, shifts the word out MSB-first one bit per
// cycle through pattern_matcher, and accumulates match statistics. Results
// are held with out_valid until out_ready, then stay readable in IDLE.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : job handshake (in_word, in_pattern)
//   abort                    : cancel a job in progress (SHIFT only)
//   ser_dout/ser_valid       : serial bit currently presented to the matcher
//   out_valid/out_ready      : result handshake
//   match_count, match_found : number of matches / any match
//   first_idx, last_idx      : bit index of the first / last match end
// ---------------------------------------------------------------------------
module serial_scan_ctrl
   import scan_pkg::*;
#(
   parameter  int WORD_W = 20,
   parameter  int PAT_W  = 4,
   localparam int CNT_W  = cnt_width(WORD_W),
   localparam int IDX_W  = idx_width(WORD_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic [PAT_W-1:0]  in_pattern,
   input  logic              abort,
   output logic              ser_dout,
   output logic              ser_valid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_count,
   output logic              match_found,
   output logic [IDX_W-1:0]  first_idx,
   output logic [IDX_W-1:0]  last_idx
);

   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WORD_W - 1);

   scan_state_t       state_reg;
   logic              in_ready_reg;
   logic              out_valid_reg;
   logic              ser_valid_reg;
   logic [WORD_W-1:0] word_reg;
   logic [PAT_W-1:0]  pattern_reg;
   logic [IDX_W-1:0]  bit_cnt_reg;
   logic [CNT_W-1:0]  match_count_reg;
   logic              match_found_reg;
   logic [IDX_W-1:0]  first_idx_reg;
   logic [IDX_W-1:0]  last_idx_reg;

   logic accept;
   logic abort_now;
   logic hit;

   assign accept    = (state_reg == ST_IDLE) && in_valid && in_ready_reg;
   assign abort_now = (state_reg == ST_SHIFT) && abort;

   pattern_matcher #(
      .PAT_W (PAT_W)
   ) u_matcher (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept || abort_now),
      .bit_in  (word_reg[WORD_W-1]),
      .bit_en  (ser_valid_reg),
      .pattern (pattern_reg),
      .hit     (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         in_ready_reg    <= 1'b1;
         out_valid_reg   <= 1'b0;
         ser_valid_reg   <= 1'b0;
         word_reg        <= '0;
         pattern_reg     <= '0;
         bit_cnt_reg     <= '0;
         match_count_reg <= '0;
         match_found_reg <= 1'b0;
         first_idx_reg   <= '0;
         last_idx_reg    <= '0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  state_reg       <= ST_SHIFT;
                  in_ready_reg    <= 1'b0;
                  ser_valid_reg   <= 1'b1;
                  word_reg        <= in_word;
                  pattern_reg     <= in_pattern;
                  bit_cnt_reg     <= '0;
                  match_count_reg <= '0;
                  match_found_reg <= 1'b0;
                  first_idx_reg   <= '0;
                  last_idx_reg    <= '0;
               end
            end

            ST_SHIFT: begin
               if (abort) begin
                  state_reg       <= ST_IDLE;
                  in_ready_reg    <= 1'b1;
                  ser_valid_reg   <= 1'b0;
                  word_reg        <= '0;
                  bit_cnt_reg     <= '0;
                  match_count_reg <= '0;
                  match_found_reg <= 1'b0;
                  first_idx_reg   <= '0;
                  last_idx_reg    <= '0;
               end else begin
                  // Zero fill: the word is all zeros once the last bit has
                  // left, so ser_dout needs no gating outside SHIFT.
                  word_reg    <= {word_reg[WORD_W-2:0], 1'b0};
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (hit) begin
                     match_count_reg <= match_count_reg + 1'b1;
                     match_found_reg <= 1'b1;
                     last_idx_reg    <= bit_cnt_reg;
                     if (!match_found_reg) begin
                        first_idx_reg <= bit_cnt_reg;
                     end
                  end
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_reg     <= ST_DONE;
                     ser_valid_reg <= 1'b0;
                     out_valid_reg <= 1'b1;
                     bit_cnt_reg   <= '0;
                  end
               end
            end

            ST_DONE: begin
               // in_ready rises only after DONE has been left, so no job can
               // be taken in the release cycle.
               if (out_ready) begin
                  state_reg     <= ST_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = out_valid_reg;
   assign ser_valid   = ser_valid_reg;
   assign ser_dout    = word_reg[WORD_W-1];
   assign match_count = match_count_reg;
   assign match_found = match_found_reg;
   assign first_idx   = first_idx_reg;
   assign last_idx    = last_idx_reg;

endmodule

// File: tb/tb_serial_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_scan_ctrl
// Table-driven bench for serial_scan_ctrl (default 20-bit word, 4-bit
// pattern). Each accepted job pushes its expected result onto a scoreboard
// queue; the entry is popped and compared when out_valid appears. Abort and
// reset-in-SHIFT are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_serial_scan_ctrl;

   localparam int WORD_W = 20;
   localparam int PAT_W  = 4;
   localparam int CNT_W  = 5;
   localparam int IDX_W  = 5;
   localparam int NVEC   = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic [PAT_W-1:0]  in_pattern;
   logic              abort;
   logic              ser_dout;
   logic              ser_valid;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  match_count;
   logic              match_found;
   logic [IDX_W-1:0]  first_idx;
   logic [IDX_W-1:0]  last_idx;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_scan_ctrl #(
      .WORD_W (WORD_W),
      .PAT_W  (PAT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word     (in_word),
      .in_pattern  (in_pattern),
      .abort       (abort),
      .ser_dout    (ser_dout),
      .ser_valid   (ser_valid),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .match_count (match_count),
      .match_found (match_found),
      .first_idx   (first_idx),
      .last_idx    (last_idx)
   );

   typedef struct {
      logic [WORD_W-1:0] word;
      logic [PAT_W-1:0]  pat;
      int                hold;
      logic [CNT_W-1:0]  cnt;
      logic              found;
      logic [IDX_W-1:0]  first;
      logic [IDX_W-1:0]  last;
   } vec_t;

   vec_t vecs [NVEC];
   vec_t sb_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_results(input string tag, input logic [CNT_W-1:0] c, input logic f,
                                input logic [IDX_W-1:0] fi, input logic [IDX_W-1:0] la);
      check({tag, "_count"}, 64'(match_count), 64'(c));
      check({tag, "_found"}, 64'(match_found), 64'(f));
      check({tag, "_first"}, 64'(first_idx), 64'(fi));
      check({tag, "_last"},  64'(last_idx),  64'(la));
   endtask

   // Reference: slide a PAT_W window over the word, MSB first.
   function automatic vec_t model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p,
                                  input int hold);
      vec_t r;
      logic [PAT_W-1:0] win;
      r.word = w; r.pat = p; r.hold = hold;
      r.cnt = '0; r.found = 1'b0; r.first = '0; r.last = '0;
      win = '0;
      for (int k = 0; k < WORD_W; k++) begin
         win = {win[PAT_W-2:0], w[WORD_W-1-k]};
         if (k >= PAT_W - 1 && win == p) begin
            if (!r.found) r.first = IDX_W'(k);
            r.found = 1'b1;
            r.last  = IDX_W'(k);
            r.cnt   = r.cnt + 1'b1;
         end
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input int hold,
                               input int c, input logic f, input int fi, input int la);
      vec_t r;
      r.word = w; r.pat = p; r.hold = hold;
      r.cnt = CNT_W'(c); r.found = f; r.first = IDX_W'(fi); r.last = IDX_W'(la);
      return r;
   endfunction

   // One full job through the handshake; abort is driven high while the
   // result is held in DONE, where it must have no effect.
   task automatic run_job(input vec_t v);
      vec_t e;
      logic ok;
      int   wait_cnt;
      @(negedge clk);
      check("in_ready_before_job", 64'(in_ready), 64'd1);
      in_valid   = 1'b1;
      in_word    = v.word;
      in_pattern = v.pat;
      sb_q.push_back(v);
      @(negedge clk);
      in_valid   = 1'b0;
      in_word    = WORD_W'($urandom);
      in_pattern = PAT_W'($urandom);
      ok = 1'b1;
      for (int k = 0; k < WORD_W; k++) begin
         if (ser_valid !== 1'b1 || ser_dout !== v.word[WORD_W-1-k] ||
             out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      check("ser_stream", 64'(ok), 64'd1);
      check("done_latency", 64'(out_valid), 64'd1);
      wait_cnt = 0;
      while (out_valid !== 1'b1 && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (out_valid !== 1'b1) begin
         check("result_timeout", 64'(out_valid), 64'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
         e = sb_q.pop_front();
         check_results("done", e.cnt, e.found, e.first, e.last);
         check("done_ser_valid", 64'(ser_valid), 64'd0);
         check("done_ser_dout",  64'(ser_dout),  64'd0);
         check("done_in_ready",  64'(in_ready),  64'd0);
         for (int h = 0; h < v.hold; h++) begin
            out_ready = 1'b0;
            abort     = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            check_results("hold", e.cnt, e.found, e.first, e.last);
         end
         abort     = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("idle_in_ready",  64'(in_ready),  64'd1);
         check("idle_out_valid", 64'(out_valid), 64'd0);
         check_results("idle", e.cnt, e.found, e.first, e.last);
         $display("job word=%05h pat=%b hold=%0d -> count=%0d found=%0d first=%0d last=%0d",
                  v.word, v.pat, v.hold, match_count, match_found, first_idx, last_idx);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic ok;

      // Hand-computed expectations first, then model-derived random jobs.
      vecs[0] = mk(20'hE5755, 4'b0101, 0,  5, 1'b1,  7, 19);
      vecs[1] = mk(20'h00000, 4'b0101, 2,  0, 1'b0,  0,  0);
      vecs[2] = mk(20'hFFFFF, 4'b1111, 10, 17, 1'b1, 3, 19);
      vecs[3] = mk(20'h00000, 4'b0000, 0, 17, 1'b1,  3, 19);
      vecs[4] = mk(20'h80001, 4'b1000, 1,  1, 1'b1,  3,  3);
      vecs[5] = mk(20'h80001, 4'b0001, 0,  1, 1'b1, 19, 19);
      vecs[6] = mk(20'hAAAAA, 4'b1010, 1,  9, 1'b1,  3, 19);
      for (int i = 7; i < NVEC; i++) begin
         vecs[i] = model(WORD_W'($urandom), PAT_W'($urandom_range(0, 3) == 0 ? 4'b0101 : PAT_W'($urandom)), i % 3);
      end

      rst = 1'b1; in_valid = 1'b0; in_word = '0; in_pattern = '0;
      abort = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ser_valid", 64'(ser_valid), 64'd0);
      check("rst_ser_dout",  64'(ser_dout),  64'd0);
      check_results("rst", '0, 1'b0, '0, '0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) run_job(vecs[i]);

      // Abort in the 6th SHIFT cycle, after an early match at bit 3.
      @(negedge clk);
      in_valid = 1'b1; in_word = 20'h50000; in_pattern = 4'b0101;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_abort_count", 64'(match_count), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_in_ready",  64'(in_ready),  64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_ser_valid", 64'(ser_valid), 64'd0);
      check_results("abort", '0, 1'b0, '0, '0);
      ok = 1'b1;
      for (int c = 0; c < 25; c++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
         @(negedge clk);
      end
      check("abort_quiet", 64'(ok), 64'd1);
      $display("abort sequence done");

      run_job(vecs[3]);

      // Reset in the middle of SHIFT with a new job being offered.
      @(negedge clk);
      in_valid = 1'b1; in_word = 20'hFFFFF; in_pattern = 4'b1111;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_found", 64'(match_found), 64'd1);
      rst = 1'b1; in_valid = 1'b1; in_word = 20'h12345; in_pattern = 4'b0011;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check("midrst_in_ready",  64'(in_ready),  64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_ser_valid", 64'(ser_valid), 64'd0);
      check("midrst_ser_dout",  64'(ser_dout),  64'd0);
      check_results("midrst", '0, 1'b0, '0, '0);
      @(negedge clk);
      check("post_rst_idle", 64'(ser_valid), 64'd0);
      $display("mid-shift reset sequence done");

      for (int i = 4; i < NVEC; i++) run_job(vecs[i]);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_scan_ctrl.md
SERIAL_SCAN_CTRL -- requirements
Module: serial_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 20, meaning the job word width in bits (legal range 4..64).
REQ-002 SHALL have parameter PAT_W, default 4, meaning the pattern width in bits (legal range 2..WORD_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a job is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller can accept a job.
REQ-007 SHALL have port in_word, input, WORD_W bits: the job data word.
REQ-008 SHALL have port in_pattern, input, PAT_W bits: the pattern to detect.
REQ-009 SHALL have port abort, input, 1 bit: cancel the current job.
REQ-010 SHALL have port ser_dout, output, 1 bit: the serial bit currently presented to the matcher.
REQ-011 SHALL have port ser_valid, output, 1 bit: ser_dout is live.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is available.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port match_count, output, clog2(WORD_W+1) bits: the number of matches.
REQ-015 SHALL have port match_found, output, 1 bit: at least one match occurred.
REQ-016 SHALL have port first_idx, output, clog2(WORD_W) bits: the bit index of the first match end.
REQ-017 SHALL have port last_idx, output, clog2(WORD_W) bits: the bit index of the last match end.

Function
REQ-018 SHALL implement the states IDLE, SHIFT and DONE.
REQ-019 SHALL assert in_ready only in IDLE; a job is accepted at an edge with in_valid=1 and in_ready=1.
REQ-020 SHALL capture in_word and in_pattern on acceptance, clear the match history, counters and indices, and enter SHIFT.
REQ-021 SHALL remain in SHIFT for exactly WORD_W cycles, presenting one bit per cycle MSB-first: bit index k = in_word[WORD_W-1-k], k=0..WORD_W-1; ser_valid=1 throughout.
REQ-022 SHALL score a match at bit k when k >= PAT_W-1 and the last PAT_W bits, oldest first, equal the captured pattern MSB-first; overlapping matches count.
REQ-023 SHALL, on each match, increment match_count, set match_found, load first_idx on the first match only, and load last_idx every time.
REQ-024 SHALL enter DONE on the edge that consumes bit WORD_W-1, so out_valid=1 in the cycle beginning WORD_W edges after the accept edge.
REQ-025 SHALL hold out_valid and the results stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-026 SHALL keep the results stable and readable in IDLE until the next acceptance.
REQ-027 SHALL report first_idx=0, last_idx=0 and match_count=0 when no match occurs (match_found=0).
REQ-028 SHALL, when abort=1 in SHIFT, return to IDLE on that edge without asserting out_valid, with all results cleared to 0.
REQ-029 SHALL ignore abort in IDLE and DONE.
REQ-030 SHALL accept no new job in the cycle where DONE is left; in_ready rises the following cycle.
REQ-031 SHALL drive ser_dout=0 and ser_valid=0 outside SHIFT.

Reset
REQ-032 SHALL, on rst=1 at an edge, from any state including mid-SHIFT, enter IDLE.
REQ-033 SHALL, on reset, set in_ready=1 after reset and out_valid, ser_valid, ser_dout, match_count, match_found, first_idx, last_idx and the history to 0.
REQ-034 SHALL give rst priority over abort and both handshakes.

Structure
REQ-035 SHALL place the state encoding and the clog2-derived width constants in shared package scan_pkg.
REQ-036 SHALL implement the PAT_W-bit history shift register, the comparator and the fill counter in sub-module pattern_matcher (ports clk, rst, clr, bit_in, bit_en, pattern, hit).
REQ-037 SHALL sequence, count and handshake in serial_scan_ctrl only.

Verification
REQ-038 SHALL cover: in_word=20'b1110_0101_0111_0101_0101, pattern=4'b0101 -> match_count=5, match_found=1, first_idx=7, last_idx=19, out_valid 20 cycles after accept.
REQ-039 SHALL cover: in_word=20'h00000, pattern=4'b0101 -> match_count=0, match_found=0, first_idx=0, last_idx=0.
REQ-040 SHALL cover: in_word=20'hFFFFF, pattern=4'b1111 -> match_count=17, first_idx=3, last_idx=19 (overlap).
REQ-041 SHALL cover: out_ready held low for 10 cycles after out_valid -> results and out_valid stable, in_ready=0; release -> in_ready=1 the next cycle.
REQ-042 SHALL cover: abort at the 6th SHIFT cycle -> IDLE next cycle, no out_valid, results 0; a new job then completes normally.
REQ-043 SHALL cover: rst pulsed mid-SHIFT while in_valid=1 -> all outputs at reset values, no job accepted on the reset edge.
